// File: rtl/wchb_pkg.sv
// rtl/wchb_pkg.sv - shared types, widths and C-element rule for the WCHB pipeline
package wchb_pkg;

  // Width of the completed-transfer counter exported by the pipeline
  localparam int XFER_CNT_W = 16;

  // One stage's handshake state bit; vectors of stages are built as
  // stage_state_t [N-1:0] so the type carries no depth of its own
  typedef logic stage_state_t;

  // Muller C-element: set when both inputs are high, clear when both are
  // low, otherwise keep the previous state
  function automatic stage_state_t c_next(input logic a, input logic b,
                                          input stage_state_t q);
    return (a & b) | (q & (a | b));
  endfunction

endpackage

// File: rtl/c_element_sync.sv
// rtl/c_element_sync.sv - clocked C-element, one WCHB stage state bit
module c_element_sync
  import wchb_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic o
);

  stage_state_t state_q;
  stage_state_t state_d;

  // Next state evaluated only from registered neighbour values, so a whole
  // chain of these advances by at most one stage per clock
  always_comb begin
    state_d = c_next(a, b, state_q);
  end

  // State register with asynchronous active-low reset to the configured value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign o = state_q;

endmodule

// File: rtl/wchb_sync_pipe.sv
// rtl/wchb_sync_pipe.sv - DEPTH-stage synchronous WCHB bundled-data pipeline (optional WCHB_PIPE_STATS_EN)
module wchb_sync_pipe
  import wchb_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 4,
  parameter logic [DEPTH-1:0] INIT  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  output logic                  o_ack,
  input  logic [WIDTH-1:0]      i_data,
  output logic                  o_req,
  input  logic                  i_ack,
  output logic [WIDTH-1:0]      o_data,
  output logic [DEPTH-1:0]      o_aclk,
  output logic [XFER_CNT_W-1:0] o_xfer_cnt
);

  // Stage states and the two neighbour terms each stage looks at:
  // a = left neighbour (i_req for stage 0), b = inverted right neighbour
  // (inverted i_ack for the last stage)
  stage_state_t [DEPTH-1:0] s;
  logic         [DEPTH-1:0] a_vec;
  logic         [DEPTH-1:0] b_vec;
  logic         [DEPTH-1:0] rise;

  assign a_vec = {s[DEPTH-2:0], i_req};
  assign b_vec = ~{i_ack, s[DEPTH-1:1]};

  for (genvar k = 0; k < DEPTH; k++) begin : gen_stage
    c_element_sync #(
      .INIT(INIT[k])
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .a  (a_vec[k]),
      .b  (b_vec[k]),
      .o  (s[k])
    );
  end

  // A stage is about to set on this edge when it is clear and both of its
  // inputs are high; that is the capture condition for its data register
  always_comb begin
    rise = ~s & a_vec & b_vec;
  end

  assign o_ack = s[0];
  assign o_req = s[DEPTH-1];

  // Payload registers: stage k copies stage k-1 (i_data for stage 0) only
  // on its own rising state; a falling state leaves the payload in place.
  // Stage k-1 cannot change on the edge stage k captures, because stage k
  // only sets while stage k-1 is already set.
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_src;

  assign data_src = {data_q[DEPTH-2:0], i_data};

  // Select new payload per stage from the capture strobes
  always_comb begin
    data_d = data_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (rise[k]) begin
        data_d[k] = data_src[k];
      end
    end
  end

  // Payload storage, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_data = data_q[DEPTH-1];

  // Registered capture strobes: high for the single cycle after each stage sets
  logic [DEPTH-1:0] aclk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aclk_q <= '0;
    end else begin
      aclk_q <= rise;
    end
  end

  assign o_aclk = aclk_q;

`ifdef WCHB_PIPE_STATS_EN
  // Completed output transfers: one count per rising o_req, wrapping freely
  logic [XFER_CNT_W-1:0] xfer_cnt_q;
  logic [XFER_CNT_W-1:0] xfer_cnt_d;

  // Increment whenever the last stage sets on this edge
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (rise[DEPTH-1]) begin
      xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign o_xfer_cnt = xfer_cnt_q;
`else
  assign o_xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_wchb_sync_pipe.sv
// tb/tb_wchb_sync_pipe.sv - scoreboard bench for wchb_sync_pipe
module tb_wchb_sync_pipe;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: empty pipeline out of reset
  logic             rst;
  logic             i_req;
  logic             i_ack;
  logic [WIDTH-1:0] i_data;
  logic             o_ack;
  logic             o_req;
  logic [WIDTH-1:0] o_data;
  logic [DEPTH-1:0] o_aclk;
  logic [15:0]      o_xfer_cnt;

  // DUT B: INIT=4'b0101, i_req held high, i_ack held low
  logic             rst_b;
  logic             i_req_b;
  logic             i_ack_b;
  logic [WIDTH-1:0] i_data_b;
  logic             o_ack_b;
  logic             o_req_b;
  logic [WIDTH-1:0] o_data_b;
  logic [DEPTH-1:0] o_aclk_b;
  logic [15:0]      o_xfer_cnt_b;

  wchb_sync_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(4'b0000)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_ack(o_ack), .i_data(i_data),
    .o_req(o_req), .i_ack(i_ack), .o_data(o_data), .o_aclk(o_aclk),
    .o_xfer_cnt(o_xfer_cnt)
  );

  wchb_sync_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(4'b0101)) dut_b (
    .clk(clk), .rst(rst_b), .i_req(i_req_b), .o_ack(o_ack_b), .i_data(i_data_b),
    .o_req(o_req_b), .i_ack(i_ack_b), .o_data(o_data_b), .o_aclk(o_aclk_b),
    .o_xfer_cnt(o_xfer_cnt_b)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          exp_cnt  = 0;
  bit          cons_en  = 1'b0;
  int          cons_dly_max = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
    end
  endtask

  // Monitor: every new output token must be the oldest one still expected
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b1 && o_req === 1'b1 && prev_req === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        check("sb_data", 64'(o_data), 64'(exp_q.pop_front()));
      end
    end
    prev_req = o_req;
  end

  // Consumer: four-phase acknowledge with random think time
  initial begin
    i_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (cons_en && rst === 1'b1 && o_req === 1'b1) begin
        repeat ($urandom_range(cons_dly_max, 0)) @(negedge clk);
        i_ack = 1'b1;
        for (int n = 0; n < TMO && o_req !== 1'b0; n++) @(negedge clk);
        check("cons_req_fall", 64'(o_req), 64'd0);
        repeat ($urandom_range(cons_dly_max, 0)) @(negedge clk);
        i_ack = 1'b0;
      end
    end
  end

  // Producer: one complete four-phase token, expected value queued at issue
  task automatic send(input logic [31:0] v, input int dmax);
    i_data = v;
    i_req  = 1'b1;
    exp_q.push_back(v);
    exp_cnt++;
    for (int n = 0; n < TMO && o_ack !== 1'b1; n++) @(negedge clk);
    check("prod_ack_rise", 64'(o_ack), 64'd1);
    repeat ($urandom_range(dmax, 0)) @(negedge clk);
    i_req = 1'b0;
    for (int n = 0; n < TMO && o_ack !== 1'b0; n++) @(negedge clk);
    check("prod_ack_fall", 64'(o_ack), 64'd0);
    repeat ($urandom_range(dmax, 0)) @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * TMO &&
         (exp_q.size() != 0 || o_req !== 1'b0 || i_ack !== 1'b0 || o_ack !== 1'b0); n++)
      @(negedge clk);
    check("drain_idle", 64'(exp_q.size() == 0 && o_req === 1'b0 && o_ack === 1'b0), 64'd1);
    repeat (2 * DEPTH) @(negedge clk);
  endtask

  // Expected DUT B handshake outputs per edge after reset release
  logic [5:0] b_tab [4];

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    b_tab[0] = {1'b1, 1'b1, 4'b1000};
    b_tab[1] = {1'b1, 1'b1, 4'b0000};
    b_tab[2] = {1'b1, 1'b1, 4'b0010};
    b_tab[3] = {1'b1, 1'b1, 4'b0000};

    rst = 1'b0; rst_b = 1'b0;
    i_req = 1'b0; i_data = '0;
    i_req_b = 1'b1; i_ack_b = 1'b0; i_data_b = $urandom;
    repeat (2) @(negedge clk);

    check("rst_ack", 64'(o_ack), 64'd0);
    check("rst_req", 64'(o_req), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_aclk", 64'(o_aclk), 64'd0);
    check("rst_cnt", 64'(o_xfer_cnt), 64'd0);
    check("b_rst_ack", 64'(o_ack_b), 64'd1);
    check("b_rst_req", 64'(o_req_b), 64'd0);
    check("b_rst_data", 64'(o_data_b), 64'd0);

    rst = 1'b1; rst_b = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      check($sformatf("b_edge%0d", e + 1), 64'({o_ack_b, o_req_b, o_aclk_b}), 64'(b_tab[e]));
    end
    check("b_data", 64'(o_data_b), 64'd0);

    // Single token through an empty pipeline
    i_data = 32'hA5A5_0001; i_req = 1'b1;
    exp_q.push_back(32'hA5A5_0001); exp_cnt++;
    @(negedge clk);
    check("lat_ack_e1", 64'(o_ack), 64'd1);
    check("lat_aclk_e1", 64'(o_aclk), 64'b0001);
    @(negedge clk);
    check("lat_aclk_e2", 64'(o_aclk), 64'b0010);
    @(negedge clk);
    check("lat_aclk_e3", 64'(o_aclk), 64'b0100);
    check("lat_req_e3", 64'(o_req), 64'd0);
    @(negedge clk);
    check("lat_aclk_e4", 64'(o_aclk), 64'b1000);
    check("lat_req_e4", 64'(o_req), 64'd1);
    check("lat_data_e4", 64'(o_data), 64'hA5A5_0001);
    i_req = 1'b0;
    cons_dly_max = 0; cons_en = 1'b1;
    drain();
    cons_en = 1'b0;

    // Stall: consumer idle, three tokens offered, only two fit
    send(32'd1, 0);
    send(32'd2, 0);
    i_data = 32'd3; i_req = 1'b1;
    exp_q.push_back(32'd3); exp_cnt++;
    repeat (20) @(negedge clk);
    check("stall_ack", 64'(o_ack), 64'd0);
    check("stall_req", 64'(o_req), 64'd1);
    check("stall_data", 64'(o_data), 64'd1);
    cons_dly_max = 3; cons_en = 1'b1;
    for (int n = 0; n < TMO && o_ack !== 1'b1; n++) @(negedge clk);
    check("stall_release_ack", 64'(o_ack), 64'd1);
    i_req = 1'b0;
    for (int n = 0; n < TMO && o_ack !== 1'b0; n++) @(negedge clk);
    check("stall_release_fall", 64'(o_ack), 64'd0);
    drain();
    cons_en = 1'b0;

    // Reset with a token sitting in stage 2
    i_data = 32'hDEAD_BEEF; i_req = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_aclk", 64'(o_aclk), 64'b0100);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ack", 64'(o_ack), 64'd0);
    check("mid_rst_req", 64'(o_req), 64'd0);
    check("mid_rst_data", 64'(o_data), 64'd0);
    check("mid_rst_aclk", 64'(o_aclk), 64'd0);
    check("mid_rst_cnt", 64'(o_xfer_cnt), 64'd0);
    i_req = 1'b0; exp_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    i_data = 32'h1234_5678; i_req = 1'b1;
    exp_q.push_back(32'h1234_5678); exp_cnt++;
    repeat (3) @(negedge clk);
    check("post_rst_req_e3", 64'(o_req), 64'd0);
    @(negedge clk);
    check("post_rst_req_e4", 64'(o_req), 64'd1);
    check("post_rst_data", 64'(o_data), 64'h1234_5678);
    i_req = 1'b0;
    cons_dly_max = 0; cons_en = 1'b1;
    drain();

    // Randomised producer/consumer timing
    cons_dly_max = 3;
    for (int t = 0; t < 1000; t++) begin
      send($urandom, 3);
    end
    drain();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef WCHB_PIPE_STATS_EN
    check("xfer_cnt", 64'(o_xfer_cnt), 64'(exp_cnt % 65536));
    check("b_xfer_cnt", 64'(o_xfer_cnt_b), 64'd1);
`else
    check("xfer_cnt", 64'(o_xfer_cnt), 64'd0);
    check("b_xfer_cnt", 64'(o_xfer_cnt_b), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
